// File: rtl/water_level_matrix_driver.sv
// water_level_matrix_driver: column-scanned LED matrix image of a water tank.
// Walls on the outer columns, a level bar inside, full-matrix blink on sensor error.
`default_nettype none
`timescale 1ns/1ps

module water_level_matrix_driver #(
  parameter int ROWS      = 7,
  parameter int COLS      = 5,
  parameter int LEVEL_W   = 2,
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 50
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LEVEL_W-1:0] level,
  input  logic               level_valid,
  input  logic               error,
  output logic [COLS-1:0]    col_sel,
  output logic [ROWS-1:0]    row_data,
  output logic               frame_start
);

  localparam int LEVELS = 2 ** LEVEL_W;
  localparam int SW     = $clog2(SCAN_DIV);
  localparam int CW     = $clog2(COLS);
  localparam int BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PW     = LEVEL_W + $clog2(ROWS);

  localparam logic [SW-1:0] c_SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_COL_LAST   = CW'(COLS - 1);
  localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [PW-1:0] c_ROW_SPAN   = PW'(ROWS - 1);
  localparam logic [PW-1:0] c_LVL_SPAN   = PW'(LEVELS - 1);

  logic [SW-1:0]      r_scan;
  logic [CW-1:0]      r_col;
  logic [LEVEL_W-1:0] r_pend_lvl;
  logic               r_pend_err;
  logic [LEVEL_W-1:0] r_disp_lvl;
  logic               r_disp_err;
  logic [BW-1:0]      r_blink_cnt;
  logic               r_blink_on;
  logic [COLS-1:0]    r_col_sel;
  logic [ROWS-1:0]    r_row_data;
  logic               r_frame_start;

  logic               w_scan_wrap;
  logic               w_boundary;
  logic [PW-1:0]      w_prod;
  logic [PW-1:0]      w_quot;
  logic [ROWS-1:0]    w_pattern;
  logic [COLS-1:0]    w_onehot;

  assign w_scan_wrap = (r_scan == c_SCAN_LAST);
  assign w_boundary  = w_scan_wrap && (r_col == c_COL_LAST);

  // Bar top row index q = floor(L*(ROWS-1)/(LEVELS-1)); rows 0..q are lit.
  assign w_prod   = PW'(r_disp_lvl) * c_ROW_SPAN;
  assign w_quot   = w_prod / c_LVL_SPAN;
  assign w_onehot = COLS'(1) << r_col;

  always_comb begin
    w_pattern = '0;
    if (r_disp_err) begin
      w_pattern = r_blink_on ? '1 : '0;
    end else if ((r_col == '0) || (r_col == c_COL_LAST)) begin
      w_pattern = '1;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        w_pattern[r] = (PW'(r) <= w_quot);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scan        <= '0;
      r_col         <= '0;
      r_pend_lvl    <= '0;
      r_pend_err    <= 1'b0;
      r_disp_lvl    <= '0;
      r_disp_err    <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_on    <= 1'b1;
      r_col_sel     <= '0;
      r_row_data    <= '0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_scan_wrap) begin
        r_scan <= '0;
        r_col  <= (r_col == c_COL_LAST) ? '0 : r_col + CW'(1);
      end else begin
        r_scan <= r_scan + SW'(1);
      end

      // Displayed state only changes here, so a frame is never torn.
      if (w_boundary) begin
        r_disp_lvl <= r_pend_lvl;
        r_disp_err <= r_pend_err;
        if (r_pend_err && !r_disp_err) begin
          r_blink_cnt <= '0;
          r_blink_on  <= 1'b1;
        end else if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_blink_on  <= !r_blink_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end

      if (level_valid) begin
        r_pend_lvl <= level;
        r_pend_err <= error;
      end

      r_col_sel     <= w_onehot;
      r_row_data    <= w_pattern;
      r_frame_start <= (r_col == '0) && !r_col_sel[0];
    end
  end

  assign col_sel     = r_col_sel;
  assign row_data    = r_row_data;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire
